// File: rtl/noc_params.sv
// noc_params: shared NoC widths, flit format and packetizer state encoding
package noc_params;
   localparam int VC_NUM = 2;
   localparam int VC_SIZE = $clog2(VC_NUM);
   localparam int DEST_ADDR_SIZE_X = 2;
   localparam int DEST_ADDR_SIZE_Y = 2;
   localparam int FLIT_DATA_SIZE = 16;
   localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
   typedef struct packed {
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;
   typedef union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
   } flit_data_t;
   typedef struct packed {
      flit_label_t        flit_label;
      logic [VC_SIZE-1:0] vc_id;
      flit_data_t         data;
   } flit_t;
   typedef enum logic [1:0] {IDLE, SEND_HEAD, SEND_BT} ni_state_t;
endpackage

// File: rtl/rr_vc_picker.sv
// rr_vc_picker: first requesting VC at or after the pointer, wrapping around
module rr_vc_picker
   import noc_params::*;
(
   input  logic [VC_NUM-1:0]  req,
   input  logic [VC_SIZE-1:0] ptr,
   output logic [VC_SIZE-1:0] gnt,
   output logic               any
);
   logic found;
   assign any = |req;
   // scan from the pointer upward, keeping the first hit
   always_comb begin
      gnt = '0;
      found = 1'b0;
      for (int i = 0; i < VC_NUM; i++) begin
         if (!found && req[(int'(ptr) + i) % VC_NUM]) begin
            found = 1'b1;
            gnt = VC_SIZE'((int'(ptr) + i) % VC_NUM);
         end
      end
   end
endmodule

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns a descriptor plus payload stream into a flit sequence on one downstream VC
module ni_packetizer
   import noc_params::*;
#(
   parameter int MAX_PKT_FLITS = 16,
   localparam int PKT_LEN_SIZE = $clog2(MAX_PKT_FLITS + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pkt_valid_i,
   output logic                         pkt_ready_o,
   input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
   input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
   input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
   input  logic [PKT_LEN_SIZE-1:0]      pkt_len_i,
   input  logic                         pl_valid_i,
   output logic                         pl_ready_o,
   input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
   input  logic [VC_NUM-1:0]            on_off_i,
   input  logic [VC_NUM-1:0]            vc_free_i,
   output flit_t                        data_o,
   output logic                         valid_flit_o,
   output logic                         busy_o,
   output logic                         err_o
);
   ni_state_t                    state;
   logic [VC_SIZE-1:0]           vc, rr_ptr, pick;
   logic                         pick_any;
   logic [PKT_LEN_SIZE-1:0]      len, cnt;
   logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
   logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
   logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   logic                         len_ok, last;

   rr_vc_picker u_pick (.req(on_off_i & vc_free_i), .ptr(rr_ptr), .gnt(pick), .any(pick_any));

   assign pkt_ready_o = (state == IDLE) & pick_any;
   assign pl_ready_o = (state == SEND_BT) & on_off_i[vc];
   assign busy_o = state != IDLE;
   assign len_ok = pkt_len_i != '0 && pkt_len_i <= PKT_LEN_SIZE'(MAX_PKT_FLITS);
   assign last = cnt == len - 1'b1;

   // packet FSM; every flit is registered and shown for exactly one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         valid_flit_o <= 1'b0;
         data_o <= '0;
         err_o <= 1'b0;
         rr_ptr <= '0;
         cnt <= '0;
         vc <= '0;
         len <= '0;
         x_dest <= '0;
         y_dest <= '0;
         head_pl <= '0;
      end else begin
         valid_flit_o <= 1'b0;
         err_o <= 1'b0;
         case (state)
            IDLE: if (pkt_valid_i && pkt_ready_o) begin
               if (len_ok) begin
                  vc <= pick;
                  rr_ptr <= (pick == VC_SIZE'(VC_NUM - 1)) ? '0 : pick + 1'b1;
                  len <= pkt_len_i;
                  x_dest <= pkt_x_dest_i;
                  y_dest <= pkt_y_dest_i;
                  head_pl <= pkt_head_pl_i;
                  state <= SEND_HEAD;
               end else
                  err_o <= 1'b1;
            end
            SEND_HEAD: if (on_off_i[vc]) begin
               data_o.flit_label <= (len == PKT_LEN_SIZE'(1)) ? HEADTAIL : HEAD;
               data_o.vc_id <= vc;
               data_o.data.head_data.x_dest <= x_dest;
               data_o.data.head_data.y_dest <= y_dest;
               data_o.data.head_data.head_pl <= head_pl;
               valid_flit_o <= 1'b1;
               cnt <= PKT_LEN_SIZE'(1);
               state <= (len == PKT_LEN_SIZE'(1)) ? IDLE : SEND_BT;
            end
            SEND_BT: if (pl_valid_i && pl_ready_o) begin
               data_o.flit_label <= last ? TAIL : BODY;
               data_o.vc_id <= vc;
               data_o.data.bt_pl <= pl_data_i;
               valid_flit_o <= 1'b1;
               cnt <= cnt + 1'b1;
               if (last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed scenarios for the packetizer with hand-computed flits
module tb_ni_packetizer;
   import noc_params::*;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic                         pkt_valid_i = 1'b0;
   logic                         pkt_ready_o;
   logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i = '0;
   logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i = '0;
   logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i = '0;
   logic [4:0]                   pkt_len_i = '0;
   logic                         pl_valid_i = 1'b0;
   logic                         pl_ready_o;
   logic [FLIT_DATA_SIZE-1:0]    pl_data_i = '0;
   logic [VC_NUM-1:0]            on_off_i = '1;
   logic [VC_NUM-1:0]            vc_free_i = '1;
   flit_t                        data_o;
   logic                         valid_flit_o, busy_o, err_o;
   int                           checks = 0;
   int                           failures = 0;

   ni_packetizer #(.MAX_PKT_FLITS(16)) dut (
      .clk(clk), .rst(rst),
      .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
      .pkt_x_dest_i(pkt_x_dest_i), .pkt_y_dest_i(pkt_y_dest_i),
      .pkt_head_pl_i(pkt_head_pl_i), .pkt_len_i(pkt_len_i),
      .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_data_i(pl_data_i),
      .on_off_i(on_off_i), .vc_free_i(vc_free_i),
      .data_o(data_o), .valid_flit_o(valid_flit_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   function automatic flit_t mk_head(flit_label_t l, logic [VC_SIZE-1:0] v, logic [1:0] x, logic [1:0] y,
                                     logic [HEAD_PAYLOAD_SIZE-1:0] hp);
      flit_t f;
      f.flit_label = l;
      f.vc_id = v;
      f.data.head_data.x_dest = x;
      f.data.head_data.y_dest = y;
      f.data.head_data.head_pl = hp;
      return f;
   endfunction

   function automatic flit_t mk_bt(flit_label_t l, logic [VC_SIZE-1:0] v, logic [FLIT_DATA_SIZE-1:0] pl);
      flit_t f;
      f.flit_label = l;
      f.vc_id = v;
      f.data.bt_pl = pl;
      return f;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send_desc(logic [1:0] x, logic [1:0] y, logic [HEAD_PAYLOAD_SIZE-1:0] hp, logic [4:0] len);
      pkt_valid_i = 1'b1;
      pkt_x_dest_i = x;
      pkt_y_dest_i = y;
      pkt_head_pl_i = hp;
      pkt_len_i = len;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (valid_flit_o !== 1'b0 || data_o !== flit_t'('0) || err_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_regs valid=%b data=%h err=%b busy=%b expected 0/0/0/0", valid_flit_o, data_o, err_o, busy_o);
      end
      checks++;
      if (pkt_ready_o !== 1'b1 || pl_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready pkt_ready=%b pl_ready=%b expected 1/0", pkt_ready_o, pl_ready_o);
      end
   endtask

   task automatic test_four_flit;
      logic [FLIT_DATA_SIZE-1:0] pls [3];
      flit_t exp;
      pls = '{16'h1111, 16'h2222, 16'h3333};
      send_desc(2'd1, 2'd2, 12'h3C5, 5'd4);
      #1;
      checks++;
      if (pkt_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL four_accept pkt_ready=%b expected 1", pkt_ready_o);
      end
      step();
      pkt_valid_i = 1'b0;
      pl_valid_i = 1'b1;
      pl_data_i = pls[0];
      #1;
      checks++;
      if (busy_o !== 1'b1 || valid_flit_o !== 1'b0 || pl_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL four_head_wait busy=%b valid=%b pl_ready=%b expected 1/0/0", busy_o, valid_flit_o, pl_ready_o);
      end
      step();
      exp = mk_head(HEAD, 1'b0, 2'd1, 2'd2, 12'h3C5);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp || pl_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL four_head valid=%b data=%h pl_ready=%b expected 1 %h 1", valid_flit_o, data_o, pl_ready_o, exp);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         exp = mk_bt(i == 2 ? TAIL : BODY, 1'b0, pls[i]);
         checks++;
         if (valid_flit_o !== 1'b1 || data_o !== exp) begin
            failures++;
            $display("FAIL four_bt[%0d] valid=%b data=%h expected 1 %h", i, valid_flit_o, data_o, exp);
         end
         if (i < 2) pl_data_i = pls[i + 1];
      end
      pl_valid_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || pkt_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL four_done busy=%b pkt_ready=%b expected 0/1", busy_o, pkt_ready_o);
      end
   endtask

   task automatic test_headtail;
      flit_t exp;
      send_desc(2'd3, 2'd0, 12'h055, 5'd1);
      pl_valid_i = 1'b1;
      pl_data_i = 16'hDEAD;
      step();
      pkt_valid_i = 1'b0;
      #1;
      checks++;
      if (pl_ready_o !== 1'b0 || valid_flit_o !== 1'b0) begin
         failures++;
         $display("FAIL ht_wait pl_ready=%b valid=%b expected 0/0", pl_ready_o, valid_flit_o);
      end
      step();
      exp = mk_head(HEADTAIL, 1'b1, 2'd3, 2'd0, 12'h055);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp || pl_ready_o !== 1'b0 || pkt_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL ht_flit valid=%b data=%h pl_ready=%b pkt_ready=%b busy=%b expected 1 %h 0 1 0",
                  valid_flit_o, data_o, pl_ready_o, pkt_ready_o, busy_o, exp);
      end
      pl_valid_i = 1'b0;
      step();
      checks++;
      if (valid_flit_o !== 1'b0) begin
         failures++;
         $display("FAIL ht_deassert valid=%b expected 0", valid_flit_o);
      end
   endtask

   task automatic test_stall;
      logic [FLIT_DATA_SIZE-1:0] pls [3];
      flit_t exp;
      pls = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      send_desc(2'd2, 2'd1, 12'h7E1, 5'd4);
      step();
      pkt_valid_i = 1'b0;
      step();
      exp = mk_head(HEAD, 1'b0, 2'd2, 2'd1, 12'h7E1);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp) begin
         failures++;
         $display("FAIL stall_head valid=%b data=%h expected 1 %h", valid_flit_o, data_o, exp);
      end
      on_off_i = 2'b10;
      pl_valid_i = 1'b1;
      pl_data_i = pls[0];
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (valid_flit_o !== 1'b0 || busy_o !== 1'b1 || pl_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_cycle[%0d] valid=%b busy=%b pl_ready=%b expected 0/1/0", i, valid_flit_o, busy_o, pl_ready_o);
         end
      end
      on_off_i = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step();
         exp = mk_bt(i == 2 ? TAIL : BODY, 1'b0, pls[i]);
         checks++;
         if (valid_flit_o !== 1'b1 || data_o !== exp) begin
            failures++;
            $display("FAIL stall_bt[%0d] valid=%b data=%h expected 1 %h", i, valid_flit_o, data_o, exp);
         end
         if (i < 2) pl_data_i = pls[i + 1];
      end
      pl_valid_i = 1'b0;
   endtask

   task automatic test_vc_select;
      logic [VC_NUM-1:0]  frees [3];
      logic [VC_SIZE-1:0] vcs [3];
      flit_t exp;
      frees = '{2'b11, 2'b11, 2'b10};
      vcs = '{1'b0, 1'b1, 1'b1};
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_desc(2'(i), 2'(i), 12'h100 + 12'(i), 5'd1);
         vc_free_i = frees[i];
         #1;
         checks++;
         if (pkt_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL vc_ready[%0d] pkt_ready=%b expected 1", i, pkt_ready_o);
         end
         step();
         pkt_valid_i = 1'b0;
         vc_free_i = 2'b11;
         step();
         exp = mk_head(HEADTAIL, vcs[i], 2'(i), 2'(i), 12'h100 + 12'(i));
         checks++;
         if (valid_flit_o !== 1'b1 || data_o !== exp) begin
            failures++;
            $display("FAIL vc_pick[%0d] valid=%b data=%h expected 1 %h", i, valid_flit_o, data_o, exp);
         end
      end
      vc_free_i = 2'b00;
      #1;
      checks++;
      if (pkt_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL vc_none_free pkt_ready=%b expected 0", pkt_ready_o);
      end
      vc_free_i = 2'b10;
      on_off_i = 2'b01;
      #1;
      checks++;
      if (pkt_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL vc_disjoint pkt_ready=%b expected 0", pkt_ready_o);
      end
      vc_free_i = 2'b11;
      on_off_i = 2'b11;
   endtask

   task automatic test_bad_len;
      logic [4:0] bad [2];
      flit_t exp;
      bad = '{5'd0, 5'd17};
      vc_free_i = 2'b01;
      for (int i = 0; i < 2; i++) begin
         send_desc(2'd1, 2'd1, 12'hFFF, bad[i]);
         step();
         pkt_valid_i = 1'b0;
         checks++;
         if (err_o !== 1'b1 || valid_flit_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL bad_len_err[%0d] err=%b valid=%b busy=%b expected 1/0/0", i, err_o, valid_flit_o, busy_o);
         end
         step();
         checks++;
         if (err_o !== 1'b0 || valid_flit_o !== 1'b0) begin
            failures++;
            $display("FAIL bad_len_pulse[%0d] err=%b valid=%b expected 0/0", i, err_o, valid_flit_o);
         end
      end
      send_desc(2'd1, 2'd1, 12'hABC, 5'd2);
      step();
      pkt_valid_i = 1'b0;
      pl_valid_i = 1'b1;
      pl_data_i = 16'h5A5A;
      step();
      exp = mk_head(HEAD, 1'b0, 2'd1, 2'd1, 12'hABC);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp) begin
         failures++;
         $display("FAIL bad_len_next_head valid=%b data=%h expected 1 %h", valid_flit_o, data_o, exp);
      end
      step();
      exp = mk_bt(TAIL, 1'b0, 16'h5A5A);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp) begin
         failures++;
         $display("FAIL bad_len_next_tail valid=%b data=%h expected 1 %h", valid_flit_o, data_o, exp);
      end
      pl_valid_i = 1'b0;
      vc_free_i = 2'b11;
   endtask

   task automatic test_reset_mid;
      flit_t exp;
      send_desc(2'd0, 2'd3, 12'h016, 5'd16);
      step();
      pkt_valid_i = 1'b0;
      pl_valid_i = 1'b1;
      pl_data_i = 16'h0B0D;
      step();
      step();
      exp = mk_bt(BODY, 1'b1, 16'h0B0D);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp || pl_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_body valid=%b data=%h pl_ready=%b expected 1 %h 1", valid_flit_o, data_o, pl_ready_o, exp);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      pl_valid_i = 1'b0;
      checks++;
      if (valid_flit_o !== 1'b0 || busy_o !== 1'b0 || pkt_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset valid=%b busy=%b pkt_ready=%b expected 0/0/1", valid_flit_o, busy_o, pkt_ready_o);
      end
      send_desc(2'd2, 2'd2, 12'h001, 5'd1);
      step();
      pkt_valid_i = 1'b0;
      step();
      exp = mk_head(HEADTAIL, 1'b0, 2'd2, 2'd2, 12'h001);
      checks++;
      if (valid_flit_o !== 1'b1 || data_o !== exp) begin
         failures++;
         $display("FAIL mid_after valid=%b data=%h expected 1 %h", valid_flit_o, data_o, exp);
      end
   endtask

   initial begin
      test_reset();
      test_four_flit();
      test_headtail();
      test_stall();
      test_vc_select();
      test_bad_len();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
